// File: rtl/or_equiv_bist_pkg.sv
// Shared types and constants for the golden-vs-netlist equivalence BIST.
package or_equiv_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load and step enable.
module bist_lfsr16
    import or_equiv_bist_pkg::*;
#(
    parameter logic [15:0] RST_VAL = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q <= RST_VAL;
        else if (load) q <= seed;
        else if (step) q <= lfsr_step(q);
    end

endmodule

// File: rtl/or_equiv_bist.sv
// Stimulus-and-compare engine: exhaustive then LFSR vectors into golden and
// netlist copies, mismatch counting and first-failure capture.
module or_equiv_bist
    import or_equiv_bist_pkg::*;
#(
    parameter int          IN_W          = 2,
    parameter int          OUT_W         = 1,
    parameter int          RAND_VECTORS  = 500,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED,
    parameter int          CNT_W         = $clog2(2**IN_W + RAND_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] golden_out,
    input  logic [OUT_W-1:0] netlist_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] first_fail_vec,
    output logic [IN_W-1:0]  first_fail_stim,
    output logic [OUT_W-1:0] first_fail_golden,
    output logic [OUT_W-1:0] first_fail_netlist,
    output logic             first_fail_valid
);

    localparam int NEXH = 2**IN_W;
    localparam int NVEC = NEXH + RAND_VECTORS;
    localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_VEC    = CNT_W'(NVEC - 1);
    localparam logic [CNT_W-1:0] EXH_END     = CNT_W'(NEXH);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t            state, nxt;
    logic [SW-1:0]     settle_cnt;
    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_unused;
    logic              accept, last, mismatch, lfsr_adv;
    logic [CNT_W-1:0]  vec_nxt;
    logic [IN_W-1:0]   stim_nxt;

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign last     = (vec_cnt == LAST_VEC);
    // 4-state inequality so an X/Z from either copy is flagged in simulation.
    assign mismatch = (golden_out !== netlist_out);
    assign vec_nxt  = vec_cnt + CNT_W'(1);
    assign stim_nxt = (vec_nxt < EXH_END) ? vec_nxt[IN_W-1:0] : lfsr_q[IN_W-1:0];
    assign lfsr_adv = (state == S_DRIVE) && (vec_cnt >= EXH_END);
    assign lfsr_unused = lfsr_q;

    bist_lfsr16 #(.RST_VAL(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .seed  (LFSR_SEED),
        .step  (lfsr_adv),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) nxt = S_DRIVE;
            S_DRIVE:        nxt = (SETTLE_CYCLES == 0) ? S_COMPARE : S_SETTLE;
            S_SETTLE:       if (settle_cnt == SETTLE_LAST) nxt = S_COMPARE;
            S_COMPARE:      nxt = last ? S_DONE : S_DRIVE;
            default:        nxt = S_IDLE;
        endcase
    end

    // stim is loaded on the edge entering DRIVE, so the DUTs see each vector
    // for DRIVE + SETTLE cycles before the compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim               <= '0;
            vec_cnt            <= '0;
            mismatch_cnt       <= '0;
            settle_cnt         <= '0;
            first_fail_vec     <= '0;
            first_fail_stim    <= '0;
            first_fail_golden  <= '0;
            first_fail_netlist <= '0;
            first_fail_valid   <= 1'b0;
        end else begin
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + SW'(1) : '0;
            if (accept) begin
                stim               <= '0;
                vec_cnt            <= '0;
                mismatch_cnt       <= '0;
                first_fail_vec     <= '0;
                first_fail_stim    <= '0;
                first_fail_golden  <= '0;
                first_fail_netlist <= '0;
                first_fail_valid   <= 1'b0;
            end else if (state == S_COMPARE) begin
                if (mismatch) begin
                    if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                    if (!first_fail_valid) begin
                        first_fail_vec     <= vec_cnt;
                        first_fail_stim    <= stim;
                        first_fail_golden  <= golden_out;
                        first_fail_netlist <= netlist_out;
                        first_fail_valid   <= 1'b1;
                    end
                end
                if (!last) begin
                    vec_cnt <= vec_nxt;
                    stim    <= stim_nxt;
                end
            end
        end
    end

    assign busy = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_COMPARE);
    assign done = (state == S_DONE);
    assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_or_equiv_bist.sv
// Bench for or_equiv_bist: three configurations checked against a vector-level model.
module tb_or_equiv_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] start_v = 3'b000;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: defaults; B: RAND_VECTORS=0, SETTLE_CYCLES=0; C: SETTLE_CYCLES=3, 20 random
    logic [1:0] stim_a, ffs_a;  logic gold_a, net_a, busy_a, done_a, pass_a, ffg_a, ffn_a, ffval_a;
    logic [8:0] mm_a, vec_a, ffv_a;
    logic [1:0] stim_b, ffs_b;  logic gold_b, net_b, busy_b, done_b, pass_b, ffg_b, ffn_b, ffval_b;
    logic [2:0] mm_b, vec_b, ffv_b;
    logic [1:0] stim_c, ffs_c;  logic gold_c, net_c, busy_c, done_c, pass_c, ffg_c, ffn_c, ffval_c;
    logic [4:0] mm_c, vec_c, ffv_c;
    logic [4:0] dly_c;

    int mode_a = 0;   // 0 OR, 1 OR with one corrupted input pattern
    int mode_b = 0;   // 0 OR, 1 stuck-at-0, 2 AND
    int ndly_c = 4;   // register stages on the netlist copy of C
    logic [1:0] bad_a = 2'b00;
    logic [1:0] prev_c = 2'b00;

    assign gold_a = |stim_a;
    assign net_a  = (mode_a == 1) ? ((|stim_a) ^ (stim_a == bad_a)) : |stim_a;
    assign gold_b = |stim_b;
    assign net_b  = (mode_b == 1) ? 1'b0 : (mode_b == 2) ? &stim_b : |stim_b;
    assign gold_c = |stim_c;
    assign net_c  = dly_c[ndly_c-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly_c <= '0;
        else        dly_c <= {dly_c[3:0], |stim_c};
    end

    or_equiv_bist u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stim(stim_a),
        .golden_out(gold_a), .netlist_out(net_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .mismatch_cnt(mm_a), .vec_cnt(vec_a), .first_fail_vec(ffv_a),
        .first_fail_stim(ffs_a), .first_fail_golden(ffg_a), .first_fail_netlist(ffn_a),
        .first_fail_valid(ffval_a));

    or_equiv_bist #(.RAND_VECTORS(0), .SETTLE_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stim(stim_b),
        .golden_out(gold_b), .netlist_out(net_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .mismatch_cnt(mm_b), .vec_cnt(vec_b), .first_fail_vec(ffv_b),
        .first_fail_stim(ffs_b), .first_fail_golden(ffg_b), .first_fail_netlist(ffn_b),
        .first_fail_valid(ffval_b));

    or_equiv_bist #(.RAND_VECTORS(20), .SETTLE_CYCLES(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stim(stim_c),
        .golden_out(gold_c), .netlist_out(net_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .mismatch_cnt(mm_c), .vec_cnt(vec_c), .first_fail_vec(ffv_c),
        .first_fail_stim(ffs_c), .first_fail_golden(ffg_c), .first_fail_netlist(ffn_c),
        .first_fail_valid(ffval_c));

    // Common view of the selected instance
    int sel = 0;
    logic [1:0] stim_s, ffs_s;
    logic busy_s, done_s, pass_s, ffg_s, ffn_s, ffval_s;
    int mm_s, vec_s, ffv_s;

    always_comb begin
        stim_s = stim_a; ffs_s = ffs_a; busy_s = busy_a; done_s = done_a; pass_s = pass_a;
        ffg_s = ffg_a; ffn_s = ffn_a; ffval_s = ffval_a;
        mm_s = int'(mm_a); vec_s = int'(vec_a); ffv_s = int'(ffv_a);
        if (sel == 1) begin
            stim_s = stim_b; ffs_s = ffs_b; busy_s = busy_b; done_s = done_b; pass_s = pass_b;
            ffg_s = ffg_b; ffn_s = ffn_b; ffval_s = ffval_b;
            mm_s = int'(mm_b); vec_s = int'(vec_b); ffv_s = int'(ffv_b);
        end else if (sel == 2) begin
            stim_s = stim_c; ffs_s = ffs_c; busy_s = busy_c; done_s = done_c; pass_s = pass_c;
            ffg_s = ffg_c; ffn_s = ffn_c; ffval_s = ffval_c;
            mm_s = int'(mm_c); vec_s = int'(vec_c); ffv_s = int'(ffv_c);
        end
    end

    // Reference: random-phase stimulus is the low two bits of the LFSR, k steps from seed
    logic [1:0] rstim [500];

    function automatic logic [1:0] exp_stim(input int i);
        return (i < 4) ? 2'(i) : rstim[i-4];
    endfunction

    // Netlist value seen at the compare of vector i
    function automatic logic exp_net(input int s, input int i);
        logic [1:0] st;
        st = exp_stim(i);
        if (s == 0) return (mode_a == 1) ? ((|st) ^ (st == bad_a)) : |st;
        if (s == 1) return (mode_b == 1) ? 1'b0 : (mode_b == 2) ? &st : |st;
        if (ndly_c <= 4) return |st;
        return (i == 0) ? |prev_c : |exp_stim(i - 1);
    endfunction

    // Full run on instance s; optional start pulse injected mid-vector inj
    task automatic run(input int s, input int inj);
        int nv, st, emm, effv;
        logic [1:0] es, effs;
        logic g, n, effg, effn, efv;
        nv = (s == 0) ? 504 : (s == 1) ? 4 : 24;
        st = (s == 0) ? 1 : (s == 1) ? 0 : 3;
        emm = 0; effv = 0; effs = 2'b00; effg = 1'b0; effn = 1'b0; efv = 1'b0;
        sel = s;
        @(posedge clk); #1;
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        for (int i = 0; i < nv; i++) begin
            es = exp_stim(i);
            checks++;
            if (vec_s !== i || stim_s !== es || busy_s !== 1'b1 || done_s !== 1'b0 ||
                mm_s !== emm || ffval_s !== efv) begin
                errors++;
                $display("FAIL trace inst%0d v%0d: vec %0d/%0d stim %b/%b busy %b done %b mm %0d/%0d ffval %b/%b",
                         s, i, vec_s, i, stim_s, es, busy_s, done_s, mm_s, emm, ffval_s, efv);
            end
            g = |es;
            n = exp_net(s, i);
            if (g !== n) begin
                if (!efv) begin
                    efv = 1'b1; effv = i; effs = es; effg = g; effn = n;
                end
                emm++;
            end
            for (int j = 0; j < st + 2; j++) begin
                start_v[s] = (i == inj && j == 1);
                @(posedge clk); #1;
            end
        end
        start_v[s] = 1'b0;
        checks++;
        if (done_s !== 1'b1 || busy_s !== 1'b0 || pass_s !== (emm == 0)) begin
            errors++;
            $display("FAIL end_flags inst%0d: done %b busy %b pass %b, want 1 0 %b",
                     s, done_s, busy_s, pass_s, emm == 0);
        end
        checks++;
        if (mm_s !== emm || vec_s !== nv - 1 || stim_s !== exp_stim(nv - 1)) begin
            errors++;
            $display("FAIL end_counts inst%0d: mm %0d/%0d vec %0d/%0d stim %b/%b",
                     s, mm_s, emm, vec_s, nv - 1, stim_s, exp_stim(nv - 1));
        end
        checks++;
        if (ffval_s !== efv || ffv_s !== effv || ffs_s !== effs || ffg_s !== effg || ffn_s !== effn) begin
            errors++;
            $display("FAIL first_fail inst%0d: valid %b/%b vec %0d/%0d stim %b/%b gold %b/%b net %b/%b",
                     s, ffval_s, efv, ffv_s, effv, ffs_s, effs, ffg_s, effg, ffn_s, effn);
        end
        if (s == 2) prev_c = exp_stim(nv - 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            checks++;
            if (stim_s !== 0 || busy_s !== 0 || done_s !== 0 || pass_s !== 0 || mm_s !== 0 ||
                vec_s !== 0 || ffv_s !== 0 || ffs_s !== 0 || ffg_s !== 0 || ffn_s !== 0 || ffval_s !== 0) begin
                errors++;
                $display("FAIL reset inst%0d: stim %b busy %b done %b pass %b mm %0d vec %0d ffval %b, want all 0",
                         s, stim_s, busy_s, done_s, pass_s, mm_s, vec_s, ffval_s);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        sel = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_s !== 1'b0 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: busy %b done %b, want 0 0", busy_s, done_s);
        end
    endtask

    task automatic test_identical();
        mode_a = 0;
        run(0, -1);
    endtask

    task automatic test_random_fault();
        for (int k = 0; k < 2; k++) begin
            bad_a = 2'($urandom_range(0, 3));
            mode_a = 1;
            run(0, -1);
        end
    endtask

    task automatic test_start_in_done();
        sel = 0; #1;
        checks++;
        if (done_s !== 1'b1 || mm_s == 0) begin
            errors++;
            $display("FAIL pre_restart: done %b mm %0d, want done 1 and mm > 0", done_s, mm_s);
        end
        mode_a = 0;
        run(0, -1);
    endtask

    task automatic test_stuck0();
        mode_b = 1;
        run(1, -1);
        checks++;
        if (mm_s !== 3 || ffv_s !== 1 || ffs_s !== 2'b01 || ffg_s !== 1'b1 || ffn_s !== 1'b0 || pass_s !== 1'b0) begin
            errors++;
            $display("FAIL stuck0: mm %0d ffv %0d ffs %b g %b n %b pass %b, want 3 1 01 1 0 0",
                     mm_s, ffv_s, ffs_s, ffg_s, ffn_s, pass_s);
        end
    endtask

    task automatic test_and();
        mode_b = 2;
        run(1, -1);
        checks++;
        if (mm_s !== 2 || ffv_s !== 1 || ffs_s !== 2'b01) begin
            errors++;
            $display("FAIL and_gate: mm %0d ffv %0d ffs %b, want 2 1 01", mm_s, ffv_s, ffs_s);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mode_a = 0;
        sel = 0;
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        n = 0;
        while (vec_s != 10 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (vec_s != 10) begin
            errors++;
            $display("FAIL reach_vec10: vec %0d after %0d cycles, want 10", vec_s, n);
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (stim_s !== 0 || busy_s !== 0 || done_s !== 0 || pass_s !== 0 || mm_s !== 0 ||
            vec_s !== 0 || ffv_s !== 0 || ffval_s !== 0) begin
            errors++;
            $display("FAIL mid_reset: stim %b busy %b done %b mm %0d vec %0d, want all 0",
                     stim_s, busy_s, done_s, mm_s, vec_s);
        end
        prev_c = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run(0, -1);
    endtask

    task automatic test_latency();
        ndly_c = 5;
        run(2, -1);
        checks++;
        if (pass_s !== 1'b0 || ffv_s !== 1) begin
            errors++;
            $display("FAIL latency5: pass %b ffv %0d, want 0 1", pass_s, ffv_s);
        end
        ndly_c = 4;
        run(2, -1);
        checks++;
        if (pass_s !== 1'b1) begin
            errors++;
            $display("FAIL latency4: pass %b, want 1", pass_s);
        end
    endtask

    task automatic test_start_ignored();
        mode_a = 0;
        run(0, $urandom_range(5, 500));
        run(2, $urandom_range(0, 23));
        mode_b = 0;
        run(1, $urandom_range(0, 3));
    endtask

    initial begin
        logic [15:0] l;
        l = 16'hACE1;
        for (int k = 0; k < 500; k++) begin
            rstim[k] = l[1:0];
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        end
        test_reset();
        test_identical();
        test_random_fault();
        test_start_in_done();
        test_stuck0();
        test_and();
        test_reset_mid();
        test_latency();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_equiv_bist.md
Name: or_equiv_bist

Overview:
- Synthesizable stimulus-and-compare engine: the hardware counterpart of the golden-vs-post-route simulation check.
- Drives a shared stimulus bus into a golden instance and a netlist instance of a small combinational block (default: 2-input OR).
- Samples both outputs after a settle window and counts mismatches.
- Reports done and pass, plus a capture of the first failing vector, for on-chip or emulation equivalence runs.

Parameters:
- IN_W, 2: stimulus width; bit 0 = a, bit 1 = b.
- OUT_W, 1: width of each DUT output.
- RAND_VECTORS, 500: number of pseudo-random vectors after the exhaustive phase.
- SETTLE_CYCLES, 1: wait cycles between driving a vector and comparing it (0 allowed).
- LFSR_SEED, 16'hACE1: non-zero LFSR reset and start value.
- CNT_W, derived: $clog2(2**IN_W + RAND_VECTORS + 1).

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse that begins a run.
- stim, output, IN_W: registered stimulus to both DUTs.
- golden_out, input, OUT_W: golden instance output.
- netlist_out, input, OUT_W: netlist instance output.
- busy, output, 1: high from the cycle after an accepted start until DONE.
- done, output, 1: run complete; held until the next accepted start.
- pass, output, 1: done && mismatch_cnt==0.
- mismatch_cnt, output, CNT_W: saturating mismatch count.
- vec_cnt, output, CNT_W: index of the vector currently applied.
- first_fail_vec, output, CNT_W: index of the first mismatching vector.
- first_fail_stim, output, IN_W: stimulus of the first mismatching vector.
- first_fail_golden, output, OUT_W: golden value of the first mismatch.
- first_fail_netlist, output, OUT_W: netlist value of the first mismatch.
- first_fail_valid, output, 1: a first-fail capture is held.

Behaviour:
- Reset: every output 0; FSM = IDLE; LFSR = LFSR_SEED. Reset mid-run aborts immediately, with no partial done.
- FSM states: IDLE, DRIVE, SETTLE, COMPARE, DONE.
- Start acceptance:
  - IDLE or DONE + start -> DRIVE. Clears mismatch_cnt, vec_cnt, all first_fail_* fields and done; reloads LFSR_SEED.
  - start in DRIVE, SETTLE or COMPARE is ignored.
- DRIVE (1 cycle): register stim for vector vec_cnt.
  - Exhaustive phase, vec_cnt < 2**IN_W: stim = vec_cnt[IN_W-1:0], giving order {b,a} = 00, 01, 10, 11.
  - Random phase: stim = lfsr[IN_W-1:0]; the LFSR advances one step per random vector, in the DRIVE cycle.
- SETTLE: exactly SETTLE_CYCLES cycles; skipped when the parameter is 0.
- COMPARE (1 cycle): compare golden_out and netlist_out.
  - Compare uses 4-state inequality (!==); X or Z on either input counts as a mismatch.
  - On mismatch: mismatch_cnt++, saturating at all-ones.
  - First mismatch only: load the first_fail_* fields and set first_fail_valid.
  - Then, if vec_cnt == 2**IN_W + RAND_VECTORS - 1 -> DONE; else vec_cnt++ -> DRIVE.
- Timing:
  - Each vector takes SETTLE_CYCLES + 2 cycles.
  - Total run = (2**IN_W + RAND_VECTORS) * (SETTLE_CYCLES + 2) cycles from the first DRIVE.
  - done rises the cycle after the last COMPARE.
- Latency tolerance: a netlist output delayed by up to SETTLE_CYCLES + 1 register stages still compares equal.
- DONE: busy = 0, done = 1; stim holds the last vector.
- RAND_VECTORS = 0: the run ends after the exhaustive phase.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It never reaches 0 from a non-zero seed. The sequence is identical on every run.

Decomposition:
- Package or_equiv_bist_pkg holds:
  - the state_t enum;
  - LFSR_POLY = 16'hB400;
  - the DEFAULT_SEED constant.
- Sub-module: bist_lfsr16 (clk, rst_n, load, seed, step, q).
- Top level holds the FSM, counters and first-fail capture.

Test Plan:
- Golden and netlist are identical OR models, defaults -> done 1512 cycles after the first DRIVE, mismatch_cnt = 0, pass = 1, first_fail_valid = 0.
- Netlist output stuck at 0, RAND_VECTORS = 0 -> mismatch_cnt = 3, first_fail_vec = 1, first_fail_stim = 2'b01, first_fail_golden = 1, first_fail_netlist = 0, pass = 0.
- Netlist is an AND gate, RAND_VECTORS = 0 -> mismatch_cnt = 2, first_fail_vec = 1; second failing stim = 2'b10.
- Assert rst_n = 0 at vec_cnt = 10, release, then start -> all outputs 0 during reset; the stim trace of the new run is bit-identical to an uninterrupted run.
- start pulsed during SETTLE -> ignored, run length unchanged; start in DONE -> counters and done cleared and a new run begins.
- SETTLE_CYCLES = 3, netlist = golden through 4 reset-to-0 registers -> pass = 1. Through 5 registers -> pass = 0, first_fail_vec = 1.
